reg_write_arbiter: RTL and testbench



---
 rtl/reg_write_arbiter_pkg.sv | 16 +
 rtl/reg_write_arbiter_rr_priority_pick.sv | 39 +++
 rtl/reg_write_arbiter.sv | 159 +++++++++++++++
 tb/tb_reg_write_arbiter.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/reg_write_arbiter_pkg.sv
// Shared definitions for the register-file write-port arbiter.
//   ADDR_W / DATA_W : default register address / data widths
//   REG_ZERO        : the hard-wired zero register; writes to it are dropped
//   StIdle/StGrant/StLocked : arbiter state encoding (StLocked only reachable
//                     when REG_ARB_LOCK_EN is defined)
package reg_write_arbiter_pkg;

  localparam int unsigned ADDR_W   = 3;
  localparam int unsigned DATA_W   = 16;
  localparam int unsigned REG_ZERO = 0;

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StGrant  = 2'd1;
  localparam logic [1:0] StLocked = 2'd2;

endpackage

// File: rtl/reg_write_arbiter_rr_priority_pick.sv
// Combinational rotate-and-find-first picker.
// Scans req_i starting at ptr_i upward (modulo NUM_REQ); the first set bit wins.
//   req_i  : request vector
//   ptr_i  : scan start position (must be < NUM_REQ)
//   gnt_o  : one-hot grant, all zero when no request
//   idx_o  : index of the granted requester (0 when no request)
module reg_write_arbiter_rr_priority_pick #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PTR_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [PTR_W-1:0]   idx_o
);

  int unsigned      pos;
  logic [PTR_W-1:0] pos_idx;
  logic             found;

  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    found   = 1'b0;
    pos     = 0;
    pos_idx = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      pos = 32'(ptr_i) + k;
      if (pos >= NUM_REQ) pos = pos - NUM_REQ;
      pos_idx = PTR_W'(pos);
      if (!found && req_i[pos_idx]) begin
        found          = 1'b1;
        idx_o          = pos_idx;
        gnt_o[pos_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter sharing the register file's single write port.
// Optional feature macro: REG_ARB_LOCK_EN (burst lock by the granted requester).
// Ports:
//   CLK, Reset : clock, asynchronous active-high reset
//   req        : per-requester write request (level)
//   req_adrs   : packed destination addresses, slice i = requester i
//   req_data   : packed write data, slice i = requester i
//   lock       : burst hold request (ignored unless REG_ARB_LOCK_EN)
//   ack        : combinational one-hot grant; transfer on req&ack at the edge
//   rf_we      : registered register-file write enable
//   rf_adrs    : registered write address
//   rf_data    : registered write data
//   zero_drop  : registered pulse, an accepted write targeted register 0
module reg_write_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ADDR_W  = reg_write_arbiter_pkg::ADDR_W,
  parameter int unsigned DATA_W  = reg_write_arbiter_pkg::DATA_W
) (
  input  logic                      CLK,
  input  logic                      Reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] req_adrs,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        lock,
  output logic [NUM_REQ-1:0]        ack,
  output logic                      rf_we,
  output logic [ADDR_W-1:0]         rf_adrs,
  output logic [DATA_W-1:0]         rf_data,
  output logic                      zero_drop
);

  import reg_write_arbiter_pkg::*;

  localparam int unsigned PTR_W = $clog2(NUM_REQ);

  logic [PTR_W-1:0]   rr_ptr_d, rr_ptr_q;
  logic [1:0]         state_d, state_q;
  logic               rf_we_d, rf_we_q;
  logic               zero_drop_d, zero_drop_q;
  logic [ADDR_W-1:0]  rf_adrs_d, rf_adrs_q;
  logic [DATA_W-1:0]  rf_data_d, rf_data_q;

  logic [NUM_REQ-1:0] pick_gnt;
  logic [PTR_W-1:0]   pick_idx;
  logic [NUM_REQ-1:0] sel_gnt;
  logic [PTR_W-1:0]   sel_idx;
  logic [PTR_W-1:0]   next_ptr;
  logic [ADDR_W-1:0]  sel_adrs;
  logic [DATA_W-1:0]  sel_data;
  logic               xfer;
  logic               is_zero;
  logic               lock_hit;

  logic [ADDR_W-1:0]  adrs_arr [NUM_REQ];
  logic [DATA_W-1:0]  data_arr [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign adrs_arr[i] = req_adrs[i*ADDR_W +: ADDR_W];
    assign data_arr[i] = req_data[i*DATA_W +: DATA_W];
  end

  reg_write_arbiter_rr_priority_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_pick (
    .req_i (req),
    .ptr_i (rr_ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx)
  );

`ifdef REG_ARB_LOCK_EN
  logic [PTR_W-1:0] owner_d, owner_q;
`else
  // Lock input and state register have no consumers without the lock feature.
  logic unused_lock;
  logic unused_state;
  assign unused_lock  = ^lock;
  assign unused_state = ^state_q;
`endif

  always_comb begin
    sel_gnt  = pick_gnt;
    sel_idx  = pick_idx;
    lock_hit = 1'b0;
`ifdef REG_ARB_LOCK_EN
    // A locked owner that is still requesting pre-empts the round-robin scan.
    // Once it drops req, the scan resumes from owner+1 (rr_ptr already there).
    if (state_q == StLocked && req[owner_q]) begin
      sel_gnt          = '0;
      sel_gnt[owner_q] = 1'b1;
      sel_idx          = owner_q;
    end
    lock_hit = lock[sel_idx];
    owner_d  = owner_q;
`endif

    ack  = Reset ? '0 : sel_gnt;
    xfer = |ack;

    sel_adrs = adrs_arr[sel_idx];
    sel_data = data_arr[sel_idx];
    is_zero  = (sel_adrs == ADDR_W'(REG_ZERO));

    rf_we_d     = xfer & ~is_zero;
    zero_drop_d = xfer & is_zero;
    // Address/data still update on a zero-register write; only rf_we is held off.
    rf_adrs_d   = xfer ? sel_adrs : rf_adrs_q;
    rf_data_d   = xfer ? sel_data : rf_data_q;

    next_ptr = (sel_idx == PTR_W'(NUM_REQ - 1)) ? '0 : sel_idx + 1'b1;
    rr_ptr_d = xfer ? next_ptr : rr_ptr_q;

    if (!xfer) begin
      state_d = StIdle;
    end else if (lock_hit) begin
      state_d = StLocked;
    end else begin
      state_d = StGrant;
    end
`ifdef REG_ARB_LOCK_EN
    if (xfer) owner_d = sel_idx;
`endif
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      rr_ptr_q    <= '0;
      state_q     <= StIdle;
      rf_we_q     <= 1'b0;
      zero_drop_q <= 1'b0;
      rf_adrs_q   <= '0;
      rf_data_q   <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      state_q     <= state_d;
      rf_we_q     <= rf_we_d;
      zero_drop_q <= zero_drop_d;
      rf_adrs_q   <= rf_adrs_d;
      rf_data_q   <= rf_data_d;
    end
  end

`ifdef REG_ARB_LOCK_EN
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      owner_q <= '0;
    end else begin
      owner_q <= owner_d;
    end
  end
`endif

  assign rf_we     = rf_we_q;
  assign zero_drop = zero_drop_q;
  assign rf_adrs   = rf_adrs_q;
  assign rf_data   = rf_data_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
module tb_reg_write_arbiter;

  localparam int N  = 4;
  localparam int AW = 3;
  localparam int DW = 16;

  logic            CLK = 1'b0;
  logic            Reset;
  logic [N-1:0]    req;
  logic [N*AW-1:0] req_adrs;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    lock;
  logic [N-1:0]    ack;
  logic            rf_we;
  logic [AW-1:0]   rf_adrs;
  logic [DW-1:0]   rf_data;
  logic            zero_drop;

  int n_vec = 0;
  int n_bad = 0;

  reg_write_arbiter #(
    .NUM_REQ (N),
    .ADDR_W  (AW),
    .DATA_W  (DW)
  ) dut (
    .CLK       (CLK),
    .Reset     (Reset),
    .req       (req),
    .req_adrs  (req_adrs),
    .req_data  (req_data),
    .lock      (lock),
    .ack       (ack),
    .rf_we     (rf_we),
    .rf_adrs   (rf_adrs),
    .rf_data   (rf_data),
    .zero_drop (zero_drop)
  );

  always #5 CLK = ~CLK;

  // Behavioural reference: pointer as an integer, lock as (flag, owner).
  int            m_ptr;
  bit            m_locked;
  int            m_owner;
  logic          m_we, m_zd;
  logic [AW-1:0] m_adrs;
  logic [DW-1:0] m_data;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_ptr = 0; m_locked = 0; m_owner = 0;
    m_we = 0; m_zd = 0; m_adrs = '0; m_data = '0;
  endfunction

  function automatic int model_pick(input logic [N-1:0] r);
    int i;
    if (m_locked && r[m_owner]) return m_owner;
    for (int k = 0; k < N; k++) begin
      i = (m_ptr + k) % N;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  function automatic void model_update(input int g, input logic [N-1:0] lk,
                                       input logic [N*AW-1:0] a, input logic [N*DW-1:0] d);
    logic [AW-1:0] ga;
    if (g < 0) begin
      m_we = 0; m_zd = 0; m_locked = 0;
    end else begin
      ga     = a[g*AW +: AW];
      m_we   = (ga != 0);
      m_zd   = (ga == 0);
      m_adrs = ga;
      m_data = d[g*DW +: DW];
      m_ptr  = (g + 1) % N;
`ifdef REG_ARB_LOCK_EN
      m_locked = lk[g];
      m_owner  = g;
`else
      m_locked = 0;
      if (lk == '1) m_owner = 0;
`endif
    end
  endfunction

  // Starts and ends at posedge+1: drive, check ack at negedge+1, check rf at next posedge+1.
  task automatic step(input logic [N-1:0] r, input logic [N*AW-1:0] a,
                      input logic [N*DW-1:0] d, input logic [N-1:0] lk,
                      output int g, output logic [N-1:0] ack_seen);
    logic [N-1:0] exp_ack;
    req = r; req_adrs = a; req_data = d; lock = lk;
    @(negedge CLK); #1;
    g        = model_pick(r);
    exp_ack  = (g < 0) ? '0 : (N'(1) << g);
    ack_seen = ack;
    check("ack", ack, exp_ack);
    @(posedge CLK); #1;
    model_update(g, lk, a, d);
    check("rf_we", rf_we, m_we);
    check("zero_drop", zero_drop, m_zd);
    check("rf_adrs", rf_adrs, m_adrs);
    check("rf_data", rf_data, m_data);
  endtask

  task automatic do_reset();
    req = '1; lock = '0; req_adrs = '1; req_data = '1;
    #2 Reset = 1'b1;
    #1;
    check("rst_rf_we", rf_we, 1'b0);
    check("rst_zero_drop", zero_drop, 1'b0);
    check("rst_rf_adrs", rf_adrs, '0);
    check("rst_rf_data", rf_data, '0);
    check("rst_ack", ack, '0);
    model_reset();
    req = '0;
    @(negedge CLK) Reset = 1'b0;
    @(posedge CLK); #1;
  endtask

  typedef struct {
    logic [N-1:0]  r;
    int            sa;  logic [AW-1:0] aa;  logic [DW-1:0] da;
    int            sb;  logic [AW-1:0] ab;  logic [DW-1:0] db;
    logic [N-1:0]  e_ack;
    logic          e_we, e_zd;
    logic [AW-1:0] e_adrs;
    logic [DW-1:0] e_data;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int            g;
    logic [N-1:0]  ak;
    logic [N*AW-1:0] a;
    logic [N*DW-1:0] d;
    int            writes;
    int            exp_ord[6];
    logic [N-1:0]  exp1h;

    Reset = 1'b1;
    req = '0; lock = '0; req_adrs = '0; req_data = '0;
    model_reset();
    @(posedge CLK); #1;
    do_reset();

    // Directed table from reset (pointer starts at 0).
    tbl[0] = '{4'b0100, 2, 3'd3, 16'hBEEF, -1, 3'd0, 16'h0, 4'b0100, 1, 0, 3'd3, 16'hBEEF};
    tbl[1] = '{4'b1001, 3, 3'd5, 16'h0503, 0, 3'd6, 16'h0600, 4'b1000, 1, 0, 3'd5, 16'h0503};
    tbl[2] = '{4'b1001, 3, 3'd5, 16'h0503, 0, 3'd6, 16'h0600, 4'b0001, 1, 0, 3'd6, 16'h0600};
    tbl[3] = '{4'b0000, -1, 3'd0, 16'h0, -1, 3'd0, 16'h0, 4'b0000, 0, 0, 3'd6, 16'h0600};
    tbl[4] = '{4'b0010, 1, 3'd0, 16'h1234, -1, 3'd0, 16'h0, 4'b0010, 0, 1, 3'd0, 16'h1234};
    tbl[5] = '{4'b0000, -1, 3'd0, 16'h0, -1, 3'd0, 16'h0, 4'b0000, 0, 0, 3'd0, 16'h1234};
    tbl[6] = '{4'b0100, 2, 3'd7, 16'hAAAA, -1, 3'd0, 16'h0, 4'b0100, 1, 0, 3'd7, 16'hAAAA};
    tbl[7] = '{4'b0100, 2, 3'd7, 16'h5555, -1, 3'd0, 16'h0, 4'b0100, 1, 0, 3'd7, 16'h5555};

    for (int v = 0; v < 8; v++) begin
      for (int i = 0; i < N; i++) begin
        a[i*AW +: AW] = AW'(i + 1);
        d[i*DW +: DW] = DW'(16'hD000 + i);
      end
      if (tbl[v].sa >= 0) begin a[tbl[v].sa*AW +: AW] = tbl[v].aa; d[tbl[v].sa*DW +: DW] = tbl[v].da; end
      if (tbl[v].sb >= 0) begin a[tbl[v].sb*AW +: AW] = tbl[v].ab; d[tbl[v].sb*DW +: DW] = tbl[v].db; end
      step(tbl[v].r, a, d, 4'b0000, g, ak);
      check("tbl_ack", ak, tbl[v].e_ack);
      check("tbl_rf_we", rf_we, tbl[v].e_we);
      check("tbl_zero_drop", zero_drop, tbl[v].e_zd);
      check("tbl_rf_adrs", rf_adrs, tbl[v].e_adrs);
      check("tbl_rf_data", rf_data, tbl[v].e_data);
    end

    // Fairness: all four active for 8 cycles from reset.
    do_reset();
    writes = 0;
    for (int i = 0; i < N; i++) begin
      a[i*AW +: AW] = AW'(i + 1);
      d[i*DW +: DW] = DW'(16'h1000 * (i + 1));
    end
    for (int c = 0; c < 8; c++) begin
      step(4'b1111, a, d, 4'b0000, g, ak);
      exp1h = N'(1) << (c % N);
      check("fair_order", ak, exp1h);
      if (rf_we === 1'b1) writes++;
    end
    check("fair_writes", writes, 8);

    // Asynchronous reset while a write is being presented.
    check("pre_rst_we", rf_we, 1'b1);
    req = 4'b1111;
    #2 Reset = 1'b1;
    #1;
    check("mid_rst_rf_we", rf_we, 1'b0);
    check("mid_rst_zero_drop", zero_drop, 1'b0);
    check("mid_rst_ack", ack, 4'b0000);
    model_reset();
    req = '0;
    @(negedge CLK) Reset = 1'b0;
    @(posedge CLK); #1;
    step(4'b1111, a, d, 4'b0000, g, ak);
    check("post_rst_first", ak, 4'b0001);

    // Lock sequence: move pointer to 2, then requester 2 holds lock.
    do_reset();
    step(4'b0010, a, d, 4'b0000, g, ak);
`ifdef REG_ARB_LOCK_EN
    exp_ord = '{2, 2, 2, 3, 0, 1};
`else
    exp_ord = '{2, 3, 0, 1, 2, 3};
`endif
    for (int c = 0; c < 6; c++) begin
      step(4'b1111, a, d, (c < 2) ? 4'b0100 : 4'b0000, g, ak);
      exp1h = N'(1) << exp_ord[c];
      check("lock_order", ak, exp1h);
    end

    // Randomized traffic against the model, with an occasional reset.
    do_reset();
    for (int c = 0; c < 400; c++) begin
      if (c % 100 == 99) do_reset();
      a = N*AW'($urandom);
      d = {$urandom, $urandom};
      step(N'($urandom), a, d, N'($urandom_range(0, 15) & ((c % 3 == 0) ? 4'hF : 4'h0)), g, ak);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
